// File: rtl/blit_cpu_pkg.sv
// Shared types and constants for the 68000-to-memory-bus bridge.
package blit_cpu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_IACK, ST_HOLD} state_e;

  localparam logic [2:0] FC_CPU   = 3'b111;
  localparam logic [3:0] IACK_NIB = 4'hF;

  // Phase-accumulator increment: phi rate (2*CPUHZ) as a 16-bit fraction of HZ.
  function automatic logic [15:0] cpu_div(input longint hz, input longint cpuhz);
    longint q;
    q = ((2 * cpuhz) << 16) / hz;
    return q[15:0];
  endfunction
endpackage

// File: rtl/blit_cpu_bridge_if.sv
// Single-request memory bus between the CPU bridge (master) and the memory side (slave).
interface blit_cpu_bridge_if #(parameter int AW = 24);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [1:0]    cpu_wstrb;
  logic          cpu_we;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;
  logic          cpu_err;

  modport master (output cpu_req, cpu_addr, cpu_wdata, cpu_wstrb, cpu_we,
                  input  cpu_ack, cpu_rdata, cpu_err);
  modport slave  (input  cpu_req, cpu_addr, cpu_wdata, cpu_wstrb, cpu_we,
                  output cpu_ack, cpu_rdata, cpu_err);
endinterface

// File: rtl/blit_cpu_phigen.sv
// phi1/phi2 clock-enable generator and power-on reset sequencer for the 68000 core.
module blit_cpu_phigen
  import blit_cpu_pkg::*;
#(
  parameter int HZ           = 100_000_000,
  parameter int CPUHZ        = 8_000_000,
  parameter int RESET_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic enPhi1,
  output logic enPhi2,
  output logic extReset
);
  localparam logic [15:0]   CPUDIV   = cpu_div(longint'(HZ), longint'(CPUHZ));
  localparam int            CW       = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [CW-1:0] RST_LOAD = CW'(RESET_CYCLES);

  logic [15:0]   div_q, div_d;
  logic          tick_d, phase_q, phase_d, phi1_q, phi2_q, ext_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign {tick_d, div_d} = {1'b0, div_q} + {1'b0, CPUDIV};
  assign phase_d = phase_q ^ tick_d;
  assign cnt_d   = (phi1_q && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      phi1_q  <= 1'b0;
      phi2_q  <= 1'b0;
      cnt_q   <= RST_LOAD;
      ext_q   <= 1'b1;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      phi1_q  <= tick_d & ~phase_q;
      phi2_q  <= tick_d & phase_q;
      cnt_q   <= cnt_d;
      // Release lags the counter by one clk so the core sees a full final phi1.
      ext_q   <= (cnt_q != '0);
    end
  end

  assign enPhi1   = phi1_q;
  assign enPhi2   = phi2_q;
  assign extReset = ext_q;
endmodule

// File: rtl/blit_cpu_bridge.sv
// fx68k strobe cycles to cpu_req/cpu_ack bridge with IACK handling and IPL encoding.
// Optional bus-timeout watchdog enabled by defining BLIT_CPU_TIMEOUT_EN.
module blit_cpu_bridge
  import blit_cpu_pkg::*;
#(
  parameter int HZ           = 100_000_000,
  parameter int CPUHZ        = 8_000_000,
  parameter int AW           = 24,
  parameter int RESET_CYCLES = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              enPhi1,
  output logic              enPhi2,
  output logic              extReset,
  input  logic [AW-1:1]     eab,
  input  logic [15:0]       oEdb,
  input  logic              eRWn,
  input  logic              UDSn,
  input  logic              LDSn,
  input  logic [2:0]        FC,
  output logic              DTACKn,
  output logic              BERRn,
  output logic              VPAn,
  output logic [15:0]       iEdb,
  output logic [2:0]        IPLn,
  blit_cpu_bridge_if.master bus,
  input  logic [7:1]        irq,
  output logic              iack,
  output logic [2:0]        iack_level,
  input  logic [7:0]        iack_vector,
  input  logic              iack_auto
);
  blit_cpu_phigen #(.HZ(HZ), .CPUHZ(CPUHZ), .RESET_CYCLES(RESET_CYCLES)) u_phigen (
    .clk(clk), .rst_n(rst_n), .enPhi1(enPhi1), .enPhi2(enPhi2), .extReset(extReset)
  );

  state_e        state_q, state_d;
  logic          pend_q, pend_d, req_q, req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d, iedb_q, iedb_d;
  logic [1:0]    wstrb_q, wstrb_d;
  logic          dtackn_q, dtackn_d, berrn_q, berrn_d, vpan_q, vpan_d;
  logic          iack_q, iack_d;
  logic [2:0]    ilvl_q, ilvl_d, ipln_q, ipln_d;
  logic          strobe;

  assign strobe = !UDSn || !LDSn;

`ifdef BLIT_CPU_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  logic [15:0] to_q, to_d;
`else
  logic timeout_unused;
  assign timeout_unused = ^16'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    req_d    = 1'b0;
    iack_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    we_d     = we_q;
    dtackn_d = dtackn_q;
    berrn_d  = berrn_q;
    vpan_d   = vpan_q;
    iedb_d   = iedb_q;
    ilvl_d   = ilvl_q;
`ifdef BLIT_CPU_TIMEOUT_EN
    to_d     = to_q;
`endif
    ipln_d = 3'b111;
    for (int i = 1; i <= 7; i++)
      if (irq[i]) ipln_d = ~3'(i);

    // A late ack after a watchdog abort only retires the outstanding request.
    if (bus.cpu_ack && pend_q && state_q != ST_BUS) pend_d = 1'b0;

    case (state_q)
      ST_IDLE: if (!extReset && strobe && !pend_q) begin
        if (FC == FC_CPU && eab[19:16] == IACK_NIB) begin
          iack_d  = 1'b1;
          ilvl_d  = eab[3:1];
          state_d = ST_IACK;
        end else if (FC == FC_CPU) begin
          berrn_d = 1'b0;
          state_d = ST_HOLD;
        end else begin
          req_d   = 1'b1;
          addr_d  = {eab, 1'b0};
          wdata_d = oEdb;
          wstrb_d = {!UDSn, !LDSn};
          we_d    = !eRWn;
          pend_d  = 1'b1;
          state_d = ST_BUS;
`ifdef BLIT_CPU_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      ST_BUS: if (bus.cpu_ack) begin
        pend_d  = 1'b0;
        iedb_d  = bus.cpu_rdata;
        if (bus.cpu_err) berrn_d = 1'b0;
        else             dtackn_d = 1'b0;
        state_d = ST_HOLD;
      end
`ifdef BLIT_CPU_TIMEOUT_EN
      else if (to_q == TO_LIM) begin
        berrn_d = 1'b0;
        state_d = ST_HOLD;
      end else begin
        to_d = to_q + 16'd1;
      end
`endif
      ST_IACK: begin
        if (iack_auto) vpan_d = 1'b0;
        else begin
          dtackn_d = 1'b0;
          iedb_d   = {8'h00, iack_vector};
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: if (UDSn && LDSn) begin
        dtackn_d = 1'b1;
        berrn_d  = 1'b1;
        vpan_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      dtackn_q <= 1'b1;
      berrn_q  <= 1'b1;
      vpan_q   <= 1'b1;
      iedb_q   <= '0;
      iack_q   <= 1'b0;
      ilvl_q   <= '0;
      ipln_q   <= 3'b111;
`ifdef BLIT_CPU_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      dtackn_q <= dtackn_d;
      berrn_q  <= berrn_d;
      vpan_q   <= vpan_d;
      iedb_q   <= iedb_d;
      iack_q   <= iack_d;
      ilvl_q   <= ilvl_d;
      ipln_q   <= ipln_d;
`ifdef BLIT_CPU_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign bus.cpu_req   = req_q;
  assign bus.cpu_addr  = addr_q;
  assign bus.cpu_wdata = wdata_q;
  assign bus.cpu_wstrb = wstrb_q;
  assign bus.cpu_we    = we_q;
  assign DTACKn        = dtackn_q;
  assign BERRn         = berrn_q;
  assign VPAn          = vpan_q;
  assign iEdb          = iedb_q;
  assign IPLn          = ipln_q;
  assign iack          = iack_q;
  assign iack_level    = ilvl_q;
endmodule

// File: tb/tb_blit_cpu_bridge.sv
// Self-checking bench for blit_cpu_bridge: bench acts as both the 68000 core and the memory.
module tb_blit_cpu_bridge;
  localparam int HZ = 100_000_000, CPUHZ = 8_000_000, AW = 24, RC = 16, TO = 8;
  localparam longint CPUDIV_M = (longint'(2 * CPUHZ) << 16) / longint'(HZ);

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enPhi1, enPhi2, extReset;
  logic [AW-1:1] eab;
  logic [15:0]   oEdb;
  logic          eRWn, UDSn, LDSn;
  logic [2:0]    FC;
  logic          DTACKn, BERRn, VPAn;
  logic [15:0]   iEdb;
  logic [2:0]    IPLn;
  logic [7:1]    irq;
  logic          iack;
  logic [2:0]    iack_level;
  logic [7:0]    iack_vector;
  logic          iack_auto;

  blit_cpu_bridge_if #(.AW(AW)) bus ();

  blit_cpu_bridge #(.HZ(HZ), .CPUHZ(CPUHZ), .AW(AW), .RESET_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enPhi1(enPhi1), .enPhi2(enPhi2), .extReset(extReset),
    .eab(eab), .oEdb(oEdb), .eRWn(eRWn), .UDSn(UDSn), .LDSn(LDSn), .FC(FC),
    .DTACKn(DTACKn), .BERRn(BERRn), .VPAn(VPAn), .iEdb(iEdb), .IPLn(IPLn),
    .bus(bus), .irq(irq), .iack(iack), .iack_level(iack_level),
    .iack_vector(iack_vector), .iack_auto(iack_auto)
  );

  int checks = 0, errors = 0;
  logic [15:0] bmem [16];  // memory as seen on the bus side
  logic [15:0] rmem [16];  // reference: what the core intended to write

  task automatic test_reset();
    irq = 7'h7f;
    repeat (3) @(negedge clk);
    checks++; if ({extReset, DTACKn, BERRn, VPAn, IPLn} !== 7'h7f) begin
      errors++; $display("FAIL reset_ctl got %b exp 1111111", {extReset, DTACKn, BERRn, VPAn, IPLn}); end
    checks++; if ({enPhi1, enPhi2, iack, bus.cpu_req, bus.cpu_we, bus.cpu_wstrb, iack_level} !== 10'h0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0", {enPhi1, enPhi2, iack, bus.cpu_req, bus.cpu_we, bus.cpu_wstrb, iack_level}); end
    checks++; if ({bus.cpu_addr, bus.cpu_wdata, iEdb} !== 56'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {bus.cpu_addr, bus.cpu_wdata, iEdb}); end
    irq = '0;
  endtask

  task automatic test_phigen();
    int n = 0, n1 = 0, ticks = 0, bad = 0, lastp = 0, exp_t;
    @(negedge clk); rst_n = 1'b1;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (enPhi1 === 1'b1) begin if (lastp == 1 || enPhi2 === 1'b1) bad++; lastp = 1; end
      else if (enPhi2 === 1'b1) begin if (lastp != 1) bad++; lastp = 2; end
      if (extReset !== 1'b1) break;
      if (enPhi1 === 1'b1) n1++;
    end
    checks++; if (extReset !== 1'b0) begin errors++; $display("FAIL extreset_release got %b exp 0", extReset); end
    checks++; if (n1 != RC) begin errors++; $display("FAIL extreset_phi1_count got %0d exp %0d", n1, RC); end
    for (int k = 0; k < 6250; k++) begin
      @(negedge clk);
      if (enPhi1 === 1'b1) begin ticks++; if (lastp == 1 || enPhi2 === 1'b1) bad++; lastp = 1; end
      else if (enPhi2 === 1'b1) begin ticks++; if (lastp != 1) bad++; lastp = 2; end
    end
    exp_t = int'((longint'(6250) * CPUDIV_M) >> 16);
    checks++; if (ticks < exp_t - 1 || ticks > exp_t + 1) begin
      errors++; $display("FAIL phi_rate got %0d exp %0d+-1", ticks, exp_t); end
    checks++; if (bad != 0) begin errors++; $display("FAIL phi_alternate got %0d exp 0", bad); end
  endtask

  // One complete core strobe cycle with the bench answering as memory after dly clks.
  task automatic bus_cycle(input logic [AW-1:0] a, input logic [15:0] d, input bit wr, ub, lb, err, input int dly);
    int n = 0, bi, wi;
    logic [15:0] exp_rd;
    @(negedge clk);
    eab = a[AW-1:1]; oEdb = d; eRWn = ~wr; UDSn = ~ub; LDSn = ~lb; FC = 3'b101;
    @(negedge clk);
    checks++; if (bus.cpu_req !== 1'b1) begin errors++; $display("FAIL req_latency got %b exp 1", bus.cpu_req); end
    while (bus.cpu_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.cpu_req !== 1'b1) begin UDSn = 1'b1; LDSn = 1'b1; repeat (4) @(negedge clk); return; end
    checks++; if ({bus.cpu_addr, bus.cpu_wstrb, bus.cpu_we} !== {a[AW-1:1], 1'b0, ub, lb, wr}) begin
      errors++; $display("FAIL req_fields got %h exp %h", {bus.cpu_addr, bus.cpu_wstrb, bus.cpu_we}, {a[AW-1:1], 1'b0, ub, lb, wr}); end
    bi = int'(bus.cpu_addr[4:1]); wi = int'(a[4:1]);
    exp_rd = rmem[wi];
    if (wr) begin
      checks++; if (bus.cpu_wdata !== d) begin errors++; $display("FAIL wdata got %h exp %h", bus.cpu_wdata, d); end
      if (bus.cpu_wstrb[1] === 1'b1) bmem[bi][15:8] = bus.cpu_wdata[15:8];
      if (bus.cpu_wstrb[0] === 1'b1) bmem[bi][7:0]  = bus.cpu_wdata[7:0];
      if (ub) rmem[wi][15:8] = d[15:8];
      if (lb) rmem[wi][7:0]  = d[7:0];
    end
    @(negedge clk);
    checks++; if (bus.cpu_req !== 1'b0) begin errors++; $display("FAIL req_pulse got %b exp 0", bus.cpu_req); end
    repeat (dly) @(negedge clk);
    checks++; if ({DTACKn, BERRn} !== 2'b11) begin errors++; $display("FAIL early_resp got %b exp 11", {DTACKn, BERRn}); end
    bus.cpu_ack = 1'b1; bus.cpu_err = err; bus.cpu_rdata = wr ? 16'h0 : bmem[bi];
    @(negedge clk);
    bus.cpu_ack = 1'b0; bus.cpu_err = 1'b0;
    checks++; if ({DTACKn, BERRn} !== (err ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL response got %b exp %b", {DTACKn, BERRn}, err ? 2'b10 : 2'b01); end
    if (!wr) begin
      checks++; if (iEdb !== exp_rd) begin errors++; $display("FAIL read_data got %h exp %h", iEdb, exp_rd); end
    end
    UDSn = 1'b1; LDSn = 1'b1;
    @(negedge clk);
    checks++; if ({DTACKn, BERRn, VPAn} !== 3'b111) begin errors++; $display("FAIL release got %b exp 111", {DTACKn, BERRn, VPAn}); end
  endtask

  task automatic test_cpu_space();
    int nreq = 0;
    @(negedge clk); eab = '0; FC = 3'b111; eRWn = 1'b1; UDSn = 1'b0; LDSn = 1'b0;
    @(negedge clk); if (bus.cpu_req !== 1'b0) nreq++;
    checks++; if ({BERRn, DTACKn, VPAn} !== 3'b011) begin errors++; $display("FAIL cpu_space_berr got %b exp 011", {BERRn, DTACKn, VPAn}); end
    repeat (3) begin @(negedge clk); if (bus.cpu_req !== 1'b0) nreq++; end
    checks++; if (nreq != 0) begin errors++; $display("FAIL cpu_space_noreq got %0d exp 0", nreq); end
    UDSn = 1'b1; LDSn = 1'b1;
    @(negedge clk);
    checks++; if (BERRn !== 1'b1) begin errors++; $display("FAIL cpu_space_release got %b exp 1", BERRn); end
  endtask

  task automatic test_ipl();
    for (int k = 0; k < 24; k++) begin
      logic [7:1] r;
      int lvl;
      r = (k == 0) ? 7'h00 : 7'($urandom);
      irq = r;
      @(negedge clk);
      lvl = 0;
      for (int i = 7; i >= 1; i--) if (r[i] && lvl == 0) lvl = i;
      checks++; if (IPLn !== ~3'(lvl)) begin errors++; $display("FAIL ipl irq=%b got %b exp %b", r, IPLn, ~3'(lvl)); end
    end
  endtask

  task automatic test_iack(input bit auto_);
    int nreq = 0;
    irq = 7'b0010100;
    @(negedge clk);
    checks++; if (IPLn !== 3'b010) begin errors++; $display("FAIL iack_ipl got %b exp 010", IPLn); end
    eab = '0; eab[19:16] = 4'hF; eab[3:1] = 3'd5; FC = 3'b111; eRWn = 1'b1; UDSn = 1'b1; LDSn = 1'b0;
    @(negedge clk); if (bus.cpu_req !== 1'b0) nreq++;
    checks++; if ({iack, iack_level} !== 4'b1101) begin errors++; $display("FAIL iack_pulse got %b exp 1101", {iack, iack_level}); end
    iack_vector = 8'h42; iack_auto = auto_;
    @(negedge clk); if (bus.cpu_req !== 1'b0) nreq++;
    checks++; if (iack !== 1'b0) begin errors++; $display("FAIL iack_one_cycle got %b exp 0", iack); end
    checks++; if ({DTACKn, VPAn, BERRn} !== (auto_ ? 3'b101 : 3'b011)) begin
      errors++; $display("FAIL iack_resp got %b exp %b", {DTACKn, VPAn, BERRn}, auto_ ? 3'b101 : 3'b011); end
    if (!auto_) begin
      checks++; if (iEdb !== 16'h0042) begin errors++; $display("FAIL iack_vector got %h exp 0042", iEdb); end
    end
    checks++; if (nreq != 0) begin errors++; $display("FAIL iack_noreq got %0d exp 0", nreq); end
    UDSn = 1'b1; LDSn = 1'b1; iack_auto = 1'b0; irq = '0;
    @(negedge clk);
    checks++; if ({DTACKn, VPAn} !== 2'b11) begin errors++; $display("FAIL iack_release got %b exp 11", {DTACKn, VPAn}); end
  endtask

  task automatic test_random_rw();
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a;
      bit wr, ub, lb, er;
      a  = 24'h003400 | 24'(($urandom % 16) << 1);
      wr = 1'($urandom % 2); ub = 1'($urandom % 2); lb = 1'($urandom % 2);
      if (!ub && !lb) lb = 1'b1;
      er = !wr && ($urandom % 8 == 0);
      bus_cycle(a, 16'($urandom), wr, ub, lb, er, int'($urandom % 4));
    end
  endtask

`ifdef BLIT_CPU_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    @(negedge clk); eab = 23'h000080; oEdb = 16'h5a5a; eRWn = 1'b0; FC = 3'b101; UDSn = 1'b0; LDSn = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_req !== 1'b1) begin errors++; $display("FAIL tmo_req got %b exp 1", bus.cpu_req); end
    repeat (TO) @(negedge clk);
    checks++; if (BERRn !== 1'b1) begin errors++; $display("FAIL tmo_early got %b exp 1", BERRn); end
    @(negedge clk);
    checks++; if ({BERRn, DTACKn} !== 2'b01) begin errors++; $display("FAIL tmo_berr got %b exp 01", {BERRn, DTACKn}); end
    UDSn = 1'b1; LDSn = 1'b1;
    @(negedge clk);
    checks++; if (BERRn !== 1'b1) begin errors++; $display("FAIL tmo_release got %b exp 1", BERRn); end
    UDSn = 1'b0; LDSn = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.cpu_req !== 1'b0) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL tmo_blocked got %0d exp 0", n); end
    bus.cpu_ack = 1'b1; @(negedge clk); bus.cpu_ack = 1'b0;
    n = 0;
    while (bus.cpu_req !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    checks++; if (bus.cpu_req !== 1'b1) begin errors++; $display("FAIL tmo_unblock got %b exp 1", bus.cpu_req); end
    @(negedge clk); bus.cpu_ack = 1'b1; @(negedge clk); bus.cpu_ack = 1'b0;
    checks++; if (DTACKn !== 1'b0) begin errors++; $display("FAIL tmo_next_dtack got %b exp 0", DTACKn); end
    UDSn = 1'b1; LDSn = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_in_bus();
    int n = 0, n1 = 0, resp = 0;
    @(negedge clk); eab = 23'h000100; oEdb = 16'h1111; eRWn = 1'b0; FC = 3'b101; UDSn = 1'b0; LDSn = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_req !== 1'b1) begin errors++; $display("FAIL rib_req got %b exp 1", bus.cpu_req); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({extReset, DTACKn, BERRn, VPAn, IPLn} !== 7'h7f) begin
      errors++; $display("FAIL rib_ctl got %b exp 1111111", {extReset, DTACKn, BERRn, VPAn, IPLn}); end
    checks++; if ({bus.cpu_req, bus.cpu_we, bus.cpu_wstrb, bus.cpu_addr, iEdb, iack} !== 45'h0) begin
      errors++; $display("FAIL rib_outputs got %h exp 0", {bus.cpu_req, bus.cpu_we, bus.cpu_wstrb, bus.cpu_addr, iEdb, iack}); end
    UDSn = 1'b1; LDSn = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (n < 3000) begin
      @(negedge clk); n++;
      bus.cpu_ack = (n == 1);
      if (DTACKn !== 1'b1 || BERRn !== 1'b1) resp++;
      if (extReset !== 1'b1) break;
      if (enPhi1 === 1'b1) n1++;
    end
    bus.cpu_ack = 1'b0;
    checks++; if (resp != 0) begin errors++; $display("FAIL rib_ack_ignored got %0d exp 0", resp); end
    checks++; if (n1 != RC || extReset !== 1'b0) begin errors++; $display("FAIL rib_reseq got %0d exp %0d", n1, RC); end
    bus_cycle(24'h002468, 16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    eab = '0; oEdb = '0; eRWn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; FC = 3'b101;
    irq = '0; iack_vector = '0; iack_auto = 1'b0;
    bus.cpu_ack = 1'b0; bus.cpu_rdata = '0; bus.cpu_err = 1'b0;
    for (int i = 0; i < 16; i++) begin bmem[i] = '0; rmem[i] = '0; end
    test_reset();
    test_phigen();
    bus_cycle(24'h001234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    bus_cycle(24'h001234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    bus_cycle(24'h001234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    test_cpu_space();
    test_ipl();
    test_iack(1'b0);
    test_iack(1'b1);
    test_random_rw();
`ifdef BLIT_CPU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
